// File: rtl/npu_requant_writeback.sv
// npu_requant_writeback
//    Requantises a stream of INT32 accumulator beats to INT8 and writes them
//    to the output SRAM, four beats per 512-bit word.
//    Each lane goes through multiply by scale, round-half-up right shift,
//    zero-point add, optional ReLU clamp at the zero point, and INT8
//    saturation. The beat pipeline is S1 multiply, S2 round/saturate and
//    S3 pack/write, and it never stalls.
//
// Ports
//    clk_i, rst_i           clock, asynchronous active-high reset
//    start_i                one-cycle job start; job fields below are sampled with it
//    num_beats_i            beats in the job (0 = empty job, flagged as error)
//    base_addr_i            first output word address
//    scale_i, shift_i       signed multiplier, right shift amount 0..31
//    zp_i, relu_en_i        signed output zero point, lower clamp enable
//    in_valid_i/in_ready_o  accumulator beat handshake
//    in_data_i              LANES signed INT32 lanes, lane k at [32k+31:32k]
//    out_sram_*_o           write port (csb active low, wmask 1 = write byte)
//    busy_o, done_o         job running / one-cycle completion pulse
//    error_o                [1] empty job, [0] start seen while not idle (sticky)
module npu_requant_writeback #(
   parameter int LANES      = 16,
   parameter int OUT_ADDR_W = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [15:0]             num_beats_i,
   input  logic [OUT_ADDR_W-1:0]   base_addr_i,
   input  logic [15:0]             scale_i,
   input  logic [4:0]              shift_i,
   input  logic [7:0]              zp_i,
   input  logic                    relu_en_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [LANES*32-1:0]     in_data_i,
   output logic                    out_sram_csb_o,
   output logic [OUT_ADDR_W-1:0]   out_sram_addr_o,
   output logic [511:0]            out_sram_wdata_o,
   output logic [63:0]             out_sram_wmask_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [1:0]              error_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e                  state_q, state_d;
   logic [15:0]             numBeats_q, beatCnt_q;
   logic [OUT_ADDR_W-1:0]   baseAddr_q, grpIdx_q;
   logic signed [15:0]      scale_q;
   logic [4:0]              shift_q;
   logic signed [7:0]       zp_q;
   logic                    reluEn_q;
   logic [1:0]              error_q;

   logic                    inFire, lastBeat, acceptStart;

   logic signed [47:0]      prod_d [LANES];
   logic signed [47:0]      s1Prod_q [LANES];
   logic                    s1Valid_q, s1Last_q;
   logic [1:0]              s1Slot_q;

   logic [LANES*8-1:0]      s2Bytes_d, s2Bytes_q;
   logic                    s2Valid_q, s2Last_q;
   logic [1:0]              s2Slot_q;

   logic [511:0]            merged_d, packBuf_q;
   logic [63:0]             mask_d;
   logic                    groupDone;
   logic                    outCsb_q, outLast_q;
   logic [OUT_ADDR_W-1:0]   outAddr_q;
   logic [511:0]            outData_q;
   logic [63:0]             outMask_q;

   assign in_ready_o  = (state_q == RUN);
   assign inFire      = in_valid_i && in_ready_o;
   assign lastBeat    = (beatCnt_q == numBeats_q - 16'd1);
   assign acceptStart = (state_q == IDLE) && start_i;

   // Job sequencing: RUN while beats are still owed, DRAIN until the
   // write carrying the final beat has gone out, then a single DONE cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = (num_beats_i == 16'd0) ? DONE : RUN;
         RUN:     if (inFire && lastBeat) state_d = DRAIN;
         DRAIN:   if (!outCsb_q && outLast_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus the job fields captured at an accepted start.
   // A start outside IDLE leaves the job alone and only raises error bit 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         numBeats_q <= '0;
         baseAddr_q <= '0;
         scale_q    <= '0;
         shift_q    <= '0;
         zp_q       <= '0;
         reluEn_q   <= 1'b0;
         error_q    <= '0;
         beatCnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (acceptStart) begin
            numBeats_q <= num_beats_i;
            baseAddr_q <= base_addr_i;
            scale_q    <= scale_i;
            shift_q    <= shift_i;
            zp_q       <= zp_i;
            reluEn_q   <= relu_en_i;
            error_q    <= (num_beats_i == 16'd0) ? 2'b10 : 2'b00;
            beatCnt_q  <= '0;
         end else begin
            if (start_i) error_q[0] <= 1'b1;
            if (inFire) beatCnt_q <= beatCnt_q + 16'd1;
         end
      end
   end

   // S1 multiply: INT32 accumulator times signed 16-bit scale, kept as the
   // full 48-bit product so nothing is lost before rounding.
   always_comb begin
      logic signed [47:0] accExt;
      logic signed [47:0] scaleExt;
      scaleExt = {{32{scale_q[15]}}, scale_q};
      for (int k = 0; k < LANES; k++) begin
         accExt    = {{16{in_data_i[32*k+31]}}, in_data_i[32*k +: 32]};
         prod_d[k] = accExt * scaleExt;
      end
   end

   // S2 round/shift/zero-point/clamp/saturate. Arithmetic is done at 50 bits
   // so the rounding add and zero-point add can never wrap.
   always_comb begin
      logic signed [49:0] pe;
      logic signed [49:0] rnd;
      logic signed [49:0] sum;
      logic signed [49:0] r;
      logic signed [49:0] v;
      logic signed [49:0] zpExt;
      s2Bytes_d = '0;
      zpExt     = {{42{zp_q[7]}}, zp_q};
      for (int k = 0; k < LANES; k++) begin
         pe = {{2{s1Prod_q[k][47]}}, s1Prod_q[k]};
         if (shift_q == 5'd0) begin
            rnd = '0;
            sum = pe;
            r   = pe;
         end else begin
            rnd = 50'sd1 <<< (shift_q - 5'd1);
            sum = pe + rnd;
            r   = sum >>> shift_q;
         end
         v = r + zpExt;
         if (reluEn_q && (v < zpExt)) v = zpExt;
         if (v > 50'sd127)
            s2Bytes_d[8*k +: 8] = 8'h7F;
         else if (v < -50'sd128)
            s2Bytes_d[8*k +: 8] = 8'h80;
         else
            s2Bytes_d[8*k +: 8] = v[7:0];
      end
   end

   // S1 and S2 pipeline registers; valid bits follow each accepted beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1Valid_q <= 1'b0;
         s1Last_q  <= 1'b0;
         s1Slot_q  <= '0;
         for (int k = 0; k < LANES; k++) s1Prod_q[k] <= '0;
         s2Valid_q <= 1'b0;
         s2Last_q  <= 1'b0;
         s2Slot_q  <= '0;
         s2Bytes_q <= '0;
      end else begin
         s1Valid_q <= inFire;
         if (inFire) begin
            s1Last_q <= lastBeat;
            s1Slot_q <= beatCnt_q[1:0];
            for (int k = 0; k < LANES; k++) s1Prod_q[k] <= prod_d[k];
         end
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            s2Last_q  <= s1Last_q;
            s2Slot_q  <= s1Slot_q;
            s2Bytes_q <= s2Bytes_d;
         end
      end
   end

   // S3 pack: beat slot j lands in bytes [16j+15:16j]. A word is written when
   // slot 3 arrives or the job's last beat arrives; a partial word only
   // enables the bytes of the beats it actually holds.
   always_comb begin
      merged_d  = packBuf_q | ({{(512-LANES*8){1'b0}}, s2Bytes_q} << {s2Slot_q, 7'd0});
      groupDone = s2Valid_q && ((s2Slot_q == 2'd3) || s2Last_q);
      case (s2Slot_q)
         2'd0:    mask_d = 64'h0000_0000_0000_FFFF;
         2'd1:    mask_d = 64'h0000_0000_FFFF_FFFF;
         2'd2:    mask_d = 64'h0000_FFFF_FFFF_FFFF;
         default: mask_d = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   end

   // Write port register. The bus is held at zero whenever no write is
   // issued; the group index restarts at each accepted start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         packBuf_q <= '0;
         grpIdx_q  <= '0;
         outCsb_q  <= 1'b1;
         outLast_q <= 1'b0;
         outAddr_q <= '0;
         outData_q <= '0;
         outMask_q <= '0;
      end else begin
         if (groupDone) begin
            outCsb_q  <= 1'b0;
            outLast_q <= s2Last_q;
            outAddr_q <= baseAddr_q + grpIdx_q;
            outData_q <= merged_d;
            outMask_q <= mask_d;
            packBuf_q <= '0;
         end else begin
            outCsb_q  <= 1'b1;
            outLast_q <= 1'b0;
            outAddr_q <= '0;
            outData_q <= '0;
            outMask_q <= '0;
            if (s2Valid_q) packBuf_q <= merged_d;
         end
         if (acceptStart)
            grpIdx_q <= '0;
         else if (groupDone)
            grpIdx_q <= grpIdx_q + 1'b1;
      end
   end

   assign out_sram_csb_o   = outCsb_q;
   assign out_sram_addr_o  = outAddr_q;
   assign out_sram_wdata_o = outData_q;
   assign out_sram_wmask_o = outMask_q;
   assign busy_o           = (state_q == RUN) || (state_q == DRAIN);
   assign done_o           = (state_q == DONE);
   assign error_o          = error_q;

endmodule
